ll_free_list: RTL and testbench
===============================

# ll_free_list

Parametrised linked-list free-pool allocator, the successor to the fixed 4-bit pointer request generator. It keeps a pool of DEPTH node pointers as a singly linked free list in an internal next-pointer array. It hands out pointers over a valid/ready port and accepts returned pointers on a free port. It sits between the list-manipulation logic and the board wrapper: `out_ptr`/`out_ptr_vld` feed the 7-segment/LED display path, and the counters and flags feed LEDs.

## Interface
- `PTR_W`, default 4: pointer width.
- `DEPTH`, default 16: pool size; 2 ≤ DEPTH ≤ 2^PTR_W.
- `CNT_W`, default PTR_W+1: free-count width; must hold DEPTH.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `out_ptr`  out  PTR_W  pointer offered for allocation (current free-list head).
- `out_ptr_vld`  out  1  `out_ptr` is valid.
- `out_ptr_rdy`  in  1  consumer accepts; allocation when `out_ptr_vld & out_ptr_rdy`.
- `free_vld`  in  1  return `free_ptr` to the pool this cycle.
- `free_ptr`  in  PTR_W  pointer being returned.
- `free_cnt`  out  CNT_W  number of entries on the free list.
- `empty`  out  1  `free_cnt == 0`.
- `init_done`  out  1  initialisation finished.
- `err_range`  out  1  sticky: a free with `free_ptr >= DEPTH` was seen.
- `err_double`  out  1  sticky: a free of a not-allocated pointer was seen.

## Operation
- State register with two states, INIT and RUN.
- Storage:
  - `next[DEPTH]` (PTR_W each) as a register array.
  - `head`, `tail`, `init_idx` registers.
  - `alloc_map[DEPTH]` bitmap.
- Reset (`rst_n` low at an edge):
  - State goes to INIT; `init_idx`=0, `head`=0, `tail`=DEPTH-1.
  - `alloc_map`=0, `free_cnt`=0, both error flags 0.
- INIT:
  - Each cycle writes `next[init_idx] <= init_idx+1` (mod DEPTH) and increments `init_idx`.
  - After writing index DEPTH-1: go to RUN, set `free_cnt` to DEPTH and `init_done` to 1.
  - `out_ptr_vld`=0 throughout. Any `free_vld` is ignored and sets `err_double`.
- RUN, allocation (`out_ptr_vld & out_ptr_rdy`):
  - `head <= next[head]`, `alloc_map[head] <= 1`, `free_cnt` decrements.
- RUN, free (`free_vld`, accepted pointer p):
  - If `free_cnt` before the edge is 0, or it is 1 and an allocation happens the same cycle: `head <= p`, `tail <= p`.
  - Otherwise: `next[tail] <= p`, `tail <= p`.
  - In both cases `alloc_map[p] <= 0` and `free_cnt` increments.
- Simultaneous allocation and free: `free_cnt` is unchanged. The head and tail updates above apply together.
- Free rejection, checked in priority order; a rejected free changes nothing except its flag:
  - p ≥ DEPTH: set `err_range`.
  - `alloc_map[p]==0`, including p equal to the pointer being allocated this same cycle: set `err_double`.
- `out_ptr = head`, and `out_ptr_vld = (state==RUN) & (free_cnt != 0)`. Both are driven from registers only, with no combinational path from inputs.
- While `out_ptr_vld` is high and `out_ptr_rdy` is low, `out_ptr` stays stable. A free in that cycle never changes `head`.
- Error flags clear only on reset.

## Timing
- Reset values:
  - `out_ptr`=0, `out_ptr_vld`=0.
  - `free_cnt`=0, `empty`=1.
  - `init_done`=0, `err_range`=0, `err_double`=0.
- INIT length is exactly DEPTH cycles. Counting edge 1 as the first edge with `rst_n` high, `out_ptr_vld`=1, `init_done`=1 and `free_cnt`=DEPTH all become visible after edge DEPTH.
- Allocation throughput: one pointer per cycle. The next head appears one cycle after the accepting edge.
- Free-to-reuse latency when the pool is empty: the returned pointer appears on `out_ptr` with `out_ptr_vld`=1 in the next cycle.
- `free_cnt` and the flags update on the same edge as the event that causes them.
- Reset mid-operation, in either state, restarts INIT on the next edge. All outstanding allocations are forgotten.

## Test plan
- Reset release, DEPTH=16, `out_ptr_rdy`=1 held: `out_ptr_vld` rises after edge 16, then `out_ptr` reads 0,1,…,15 on consecutive cycles. `empty`=1 and `free_cnt`=0 after the 16th allocation.
- Drain all 16 pointers, free 7, then 3: `out_ptr`=7 on the next cycle and `free_cnt`=2. Allocating yields 7 then 3, then `out_ptr_vld`=0.
- `free_cnt`=1 (head 5), allocate 5 and free 9 in the same cycle: next cycle `out_ptr`=9, `free_cnt`=1, `out_ptr_vld`=1.
- Errors on a fresh pool:
  - Free 4 without allocating it: `err_double`=1, `free_cnt` unchanged.
  - With DEPTH=12, PTR_W=4: free 13 → `err_range`=1.
  - Free the pointer being allocated in the same cycle → `err_double`=1, `free_cnt` decrements by 1.
- Hold `out_ptr_rdy`=0 for 5 cycles while freeing valid pointers: `out_ptr` stays stable and `free_cnt` increases by 1 per free.
- Assert `rst_n`=0 for 1 cycle mid-stream: outputs return to reset values, INIT reruns for DEPTH cycles, and allocation order restarts at 0.

Source files
------------

// File: rtl/ll_free_list_if.sv
// ll_free_list_if: allocation / free handshake bundle for ll_free_list.
//   out_ptr      pointer offered for allocation (free-list head)
//   out_ptr_vld  out_ptr is valid
//   out_ptr_rdy  consumer accepts out_ptr this cycle
//   free_vld     free_ptr is being returned this cycle
//   free_ptr     pointer being returned to the pool
// master = the allocator, slave = the consumer / list-manipulation logic.
interface ll_free_list_if #(
   parameter int PTR_W = 4
);
   logic [PTR_W-1:0] out_ptr;
   logic             out_ptr_vld;
   logic             out_ptr_rdy;
   logic             free_vld;
   logic [PTR_W-1:0] free_ptr;

   modport master (
      output out_ptr,
      output out_ptr_vld,
      input  out_ptr_rdy,
      input  free_vld,
      input  free_ptr
   );

   modport slave (
      input  out_ptr,
      input  out_ptr_vld,
      output out_ptr_rdy,
      output free_vld,
      output free_ptr
   );
endinterface

// File: rtl/ll_free_list.sv
// ll_free_list: pool of DEPTH node pointers kept as a singly linked free list.
// After reset the list is built one link per cycle (INIT), then pointers are
// handed out from the head and returned pointers are appended at the tail.
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   bus          allocation / free handshake (master side)
//   free_cnt     number of entries on the free list
//   empty        free_cnt == 0
//   init_done    list built, allocator running
//   err_range    sticky: a freed pointer was >= DEPTH
//   err_double   sticky: a freed pointer was not allocated (or freed during INIT)
module ll_free_list #(
   parameter int PTR_W = 4,
   parameter int DEPTH = 16,
   parameter int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   ll_free_list_if.master   bus,
   output logic [CNT_W-1:0] free_cnt,
   output logic             empty,
   output logic             init_done,
   output logic             err_range,
   output logic             err_double
);

   localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(DEPTH - 1);
   localparam logic [PTR_W:0]   DEPTH_EXT = (PTR_W + 1)'(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t           state_q;
   logic [PTR_W-1:0] next_q [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [PTR_W-1:0] init_idx_q;
   logic [DEPTH-1:0] alloc_map_q, alloc_map_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_range_q, err_double_q;

   logic run, out_vld, alloc, in_range, was_alloc, free_ok, restart, link_we;

   assign run       = (state_q == ST_RUN);
   assign out_vld   = run && (cnt_q != '0);
   assign alloc     = out_vld && bus.out_ptr_rdy;
   assign in_range  = ({1'b0, bus.free_ptr} < DEPTH_EXT);
   // The head is never marked allocated, so freeing the pointer being
   // allocated in the same cycle is rejected here as a double free.
   assign was_alloc = in_range && alloc_map_q[bus.free_ptr];
   assign free_ok   = run && bus.free_vld && was_alloc;
   // List empty, or its last entry leaves this cycle: the freed pointer
   // becomes the entire list instead of being linked behind the tail.
   assign restart   = (cnt_q == '0) || ((cnt_q == CNT_W'(1)) && alloc);
   assign link_we   = free_ok && !restart;

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      if (alloc) begin
         head_d = next_q[head_q];
      end
      if (free_ok) begin
         tail_d = bus.free_ptr;
         if (restart) begin
            head_d = bus.free_ptr;
         end
      end
      if (alloc && !free_ok) begin
         cnt_d = cnt_q - CNT_W'(1);
      end else if (free_ok && !alloc) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_map
         assign alloc_map_d[gi] =
            (alloc && (head_q == PTR_W'(gi)))            ? 1'b1 :
            (free_ok && (bus.free_ptr == PTR_W'(gi)))    ? 1'b0 :
                                                           alloc_map_q[gi];
      end
   endgenerate

   // Link storage has no reset: INIT rewrites every entry before use.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (state_q == ST_INIT) begin
            next_q[init_idx_q] <= (init_idx_q == LAST_IDX) ? '0 : init_idx_q + PTR_W'(1);
         end else if (link_we) begin
            next_q[tail_q] <= bus.free_ptr;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_INIT;
         init_idx_q   <= '0;
         head_q       <= '0;
         tail_q       <= LAST_IDX;
         alloc_map_q  <= '0;
         cnt_q        <= '0;
         err_range_q  <= 1'b0;
         err_double_q <= 1'b0;
      end else begin
         case (state_q)
            ST_INIT: begin
               init_idx_q <= init_idx_q + PTR_W'(1);
               if (init_idx_q == LAST_IDX) begin
                  state_q <= ST_RUN;
                  cnt_q   <= DEPTH_CNT;
               end
               if (bus.free_vld) begin
                  err_double_q <= 1'b1;
               end
            end
            default: begin
               head_q      <= head_d;
               tail_q      <= tail_d;
               cnt_q       <= cnt_d;
               alloc_map_q <= alloc_map_d;
               if (bus.free_vld && !in_range) begin
                  err_range_q <= 1'b1;
               end
               if (bus.free_vld && in_range && !was_alloc) begin
                  err_double_q <= 1'b1;
               end
            end
         endcase
      end
   end

   assign bus.out_ptr     = head_q;
   assign bus.out_ptr_vld = out_vld;
   assign free_cnt        = cnt_q;
   assign empty           = (cnt_q == '0);
   assign init_done       = run;
   assign err_range       = err_range_q;
   assign err_double      = err_double_q;

endmodule

// File: tb/tb_ll_free_list.sv
module tb_ll_free_list;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   ll_free_list_if #(.PTR_W(4)) bus16 ();
   ll_free_list_if #(.PTR_W(4)) bus12 ();

   logic [4:0] cnt16, cnt12;
   logic       empty16, done16, er16, ed16;
   logic       empty12, done12, er12, ed12;

   ll_free_list #(.PTR_W(4), .DEPTH(16), .CNT_W(5)) u_dut16 (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus16),
      .free_cnt   (cnt16),
      .empty      (empty16),
      .init_done  (done16),
      .err_range  (er16),
      .err_double (ed16)
   );

   ll_free_list #(.PTR_W(4), .DEPTH(12), .CNT_W(5)) u_dut12 (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus12),
      .free_cnt   (cnt12),
      .empty      (empty12),
      .init_done  (done12),
      .err_range  (er12),
      .err_double (ed12)
   );

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic       rdy;
      logic       fv;
      logic [3:0] fp;
      logic       vld;
      logic [3:0] ptr;
      logic [4:0] cnt;
      logic       ed;
   } vec_t;

   vec_t vecs [20];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset16(input string tag);
      chk({tag, "_ptr"},   32'(bus16.out_ptr), 32'd0);
      chk({tag, "_vld"},   32'(bus16.out_ptr_vld), 32'd0);
      chk({tag, "_cnt"},   32'(cnt16), 32'd0);
      chk({tag, "_empty"}, 32'(empty16), 32'd1);
      chk({tag, "_done"},  32'(done16), 32'd0);
      chk({tag, "_er"},    32'(er16), 32'd0);
      chk({tag, "_ed"},    32'(ed16), 32'd0);
      chk({tag, "_ed12"},  32'(ed12), 32'd0);
      chk({tag, "_er12"},  32'(er12), 32'd0);
   endtask

   // Release reset and walk INIT; optionally poke a free into DUT12 mid-INIT.
   task automatic run_init(input bit poke12);
      rst_n = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         if (poke12 && k == 3) begin
            bus12.free_vld = 1'b1;
            bus12.free_ptr = 4'd13;
         end
         tick();
         bus12.free_vld = 1'b0;
         if (poke12 && k == 3) begin
            chk("init12_free_ed", 32'(ed12), 32'd1);
            chk("init12_free_er", 32'(er12), 32'd0);
         end
         if (k == 11) chk("init12_done_early", 32'(done12), 32'd0);
         if (k == 12) begin
            chk("init12_done", 32'(done12), 32'd1);
            chk("init12_cnt",  32'(cnt12), 32'd12);
         end
         if (k < 16) begin
            chk($sformatf("init_vld_e%0d", k),  32'(bus16.out_ptr_vld), 32'd0);
            chk($sformatf("init_done_e%0d", k), 32'(done16), 32'd0);
         end else begin
            chk("init_vld",  32'(bus16.out_ptr_vld), 32'd1);
            chk("init_done", 32'(done16), 32'd1);
            chk("init_cnt",  32'(cnt16), 32'd16);
            chk("init_ptr",  32'(bus16.out_ptr), 32'd0);
         end
      end
   endtask

   initial begin
      //          rdy   fv    fp     vld   ptr    cnt    ed
      vecs[0]  = '{1'b0, 1'b1, 4'd7, 1'b1, 4'd7, 5'd1, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 4'd3, 1'b1, 4'd7, 5'd2, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 4'd0, 1'b1, 4'd3, 5'd1, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 5'd0, 1'b0};
      vecs[4]  = '{1'b1, 1'b1, 4'd5, 1'b1, 4'd5, 5'd1, 1'b0};
      vecs[5]  = '{1'b1, 1'b1, 4'd9, 1'b1, 4'd9, 5'd1, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 4'd1, 1'b1, 4'd9, 5'd2, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 4'd2, 1'b1, 4'd9, 5'd3, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 4'd4, 1'b1, 4'd9, 5'd4, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 4'd6, 1'b1, 4'd9, 5'd5, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 4'd8, 1'b1, 4'd9, 5'd6, 1'b0};
      vecs[11] = '{1'b1, 1'b0, 4'd0, 1'b1, 4'd1, 5'd5, 1'b0};
      vecs[12] = '{1'b1, 1'b0, 4'd0, 1'b1, 4'd2, 5'd4, 1'b0};
      vecs[13] = '{1'b1, 1'b1, 4'd9, 1'b1, 4'd4, 5'd4, 1'b0};
      vecs[14] = '{1'b0, 1'b1, 4'd4, 1'b1, 4'd4, 5'd4, 1'b1};
      vecs[15] = '{1'b1, 1'b1, 4'd4, 1'b1, 4'd6, 5'd3, 1'b1};
      vecs[16] = '{1'b1, 1'b0, 4'd0, 1'b1, 4'd8, 5'd2, 1'b1};
      vecs[17] = '{1'b1, 1'b0, 4'd0, 1'b1, 4'd9, 5'd1, 1'b1};
      vecs[18] = '{1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 5'd0, 1'b1};
      vecs[19] = '{1'b0, 1'b1, 4'd5, 1'b1, 4'd5, 5'd1, 1'b1};

      rst_n             = 1'b0;
      bus16.out_ptr_rdy = 1'b1;
      bus16.free_vld    = 1'b0;
      bus16.free_ptr    = 4'd0;
      bus12.out_ptr_rdy = 1'b0;
      bus12.free_vld    = 1'b0;
      bus12.free_ptr    = 4'd0;

      tick();
      tick();
      chk_reset16("reset");

      // INIT then drain the whole pool with out_ptr_rdy held high.
      run_init(1'b0);
      for (int k = 1; k <= 16; k++) begin
         tick();
         if (k < 16) begin
            chk($sformatf("drain_ptr%0d", k), 32'(bus16.out_ptr), 32'(k));
            chk($sformatf("drain_cnt%0d", k), 32'(cnt16), 32'(16 - k));
         end else begin
            chk("drain_vld",   32'(bus16.out_ptr_vld), 32'd0);
            chk("drain_cnt",   32'(cnt16), 32'd0);
            chk("drain_empty", 32'(empty16), 32'd1);
         end
      end

      // Fresh DEPTH=12 pool: out-of-range free, then free of an unallocated pointer.
      bus12.free_vld = 1'b1;
      bus12.free_ptr = 4'd13;
      tick();
      chk("p12_range_er",  32'(er12), 32'd1);
      chk("p12_range_ed",  32'(ed12), 32'd0);
      chk("p12_range_cnt", 32'(cnt12), 32'd12);
      bus12.free_ptr = 4'd4;
      tick();
      bus12.free_vld = 1'b0;
      chk("p12_double_ed",  32'(ed12), 32'd1);
      chk("p12_double_cnt", 32'(cnt12), 32'd12);

      // Table of single-cycle transactions on the drained DEPTH=16 pool.
      for (int i = 0; i < 20; i++) begin
         bus16.out_ptr_rdy = vecs[i].rdy;
         bus16.free_vld    = vecs[i].fv;
         bus16.free_ptr    = vecs[i].fp;
         tick();
         chk($sformatf("v%0d_vld", i), 32'(bus16.out_ptr_vld), 32'(vecs[i].vld));
         if (vecs[i].vld) begin
            chk($sformatf("v%0d_ptr", i), 32'(bus16.out_ptr), 32'(vecs[i].ptr));
         end
         chk($sformatf("v%0d_cnt", i),   32'(cnt16), 32'(vecs[i].cnt));
         chk($sformatf("v%0d_empty", i), 32'(empty16), 32'(vecs[i].cnt == 5'd0));
         chk($sformatf("v%0d_ed", i),    32'(ed16), 32'(vecs[i].ed));
         chk($sformatf("v%0d_er", i),    32'(er16), 32'd0);
      end
      bus16.free_vld = 1'b0;

      // One-cycle reset mid-stream, allocation order restarts at 0.
      rst_n             = 1'b0;
      bus16.out_ptr_rdy = 1'b1;
      tick();
      chk_reset16("midrst");
      chk("midrst_done12", 32'(done12), 32'd0);
      run_init(1'b1);
      for (int k = 1; k <= 2; k++) begin
         tick();
         chk($sformatf("restart_ptr%0d", k), 32'(bus16.out_ptr), 32'(k));
         chk($sformatf("restart_cnt%0d", k), 32'(cnt16), 32'(16 - k));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
